// File: rtl/mem_arbiter.sv
// Arbitrates the single word-wide memory controller port between instruction fetch
// and data requesters; sub-word stores become read-modify-write, stalled accesses time out.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  output logic        m_re,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        err
);

  localparam int unsigned TCW = $clog2(TIMEOUT + 1);
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RMW_RD, RMW_WR} state_t;

  state_t         r_state,   w_state_nx;
  logic [SCW-1:0] r_starve,  w_starve_nx;
  logic [TCW-1:0] r_tcnt,    w_tcnt_nx;
  logic [3:0]     r_be,      w_be_nx;
  logic [31:0]    r_m_addr,  w_m_addr_nx;
  logic [31:0]    r_m_wdata, w_m_wdata_nx;
  logic           r_m_we,    w_m_we_nx;
  logic           r_m_re,    w_m_re_nx;
  logic [31:0]    r_i_rdata, w_i_rdata_nx;
  logic           r_i_ready, w_i_ready_nx;
  logic [31:0]    r_d_rdata, w_d_rdata_nx;
  logic           r_d_ready, w_d_ready_nx;
  logic           r_err,     w_err_nx;

  logic [TCW-1:0] w_tcnt_inc;
  logic           w_timeout;
  logic           w_grant_d;
  logic [31:0]    w_merged;
  logic           w_unused;

  // Controller is always word-addressed, so the low address bits are dropped.
  assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

  assign w_tcnt_inc = r_tcnt + 1'b1;
  assign w_timeout  = (w_tcnt_inc == TCW'(TIMEOUT));
  assign w_grant_d  = d_req && (!i_req || (r_starve < SCW'(STARVE_LIMIT)));

  always_comb begin
    w_merged = m_rdata;
    for (int unsigned b = 0; b < 4; b++) begin
      if (r_be[b]) w_merged[8*b +: 8] = r_m_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_starve_nx  = r_starve;
    w_tcnt_nx    = r_tcnt;
    w_be_nx      = r_be;
    w_m_addr_nx  = r_m_addr;
    w_m_wdata_nx = r_m_wdata;
    w_m_we_nx    = r_m_we;
    w_m_re_nx    = r_m_re;
    w_i_rdata_nx = r_i_rdata;
    w_i_ready_nx = 1'b0;
    w_d_rdata_nx = r_d_rdata;
    w_d_ready_nx = 1'b0;
    w_err_nx     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          if (i_req && (r_starve != SCW'(STARVE_LIMIT))) w_starve_nx = r_starve + 1'b1;
          w_m_addr_nx  = {d_addr[31:2], 2'b00};
          w_m_wdata_nx = d_wdata;
          w_be_nx      = d_be;
          w_tcnt_nx    = '0;
          if (!d_we) begin
            w_state_nx = D_RD;
            w_m_re_nx  = 1'b1;
          end else if (d_be == 4'b1111) begin
            w_state_nx = D_WR;
            w_m_we_nx  = 1'b1;
          end else if (d_be == 4'b0000) begin
            w_d_ready_nx = 1'b1;
          end else begin
            w_state_nx = RMW_RD;
            w_m_re_nx  = 1'b1;
          end
        end else if (i_req) begin
          w_starve_nx = '0;
          w_m_addr_nx = {i_addr[31:2], 2'b00};
          w_tcnt_nx   = '0;
          w_state_nx  = I_RD;
          w_m_re_nx   = 1'b1;
        end
      end

      I_RD, D_RD, D_WR, RMW_RD, RMW_WR: begin
        if (m_ready) begin
          w_m_re_nx  = 1'b0;
          w_m_we_nx  = 1'b0;
          w_state_nx = IDLE;
          case (r_state)
            I_RD: begin
              w_i_ready_nx = 1'b1;
              w_i_rdata_nx = m_rdata;
            end
            D_RD: begin
              w_d_ready_nx = 1'b1;
              w_d_rdata_nx = m_rdata;
            end
            // Read half of a sub-word store: switch straight to the write with merged data.
            RMW_RD: begin
              w_m_we_nx    = 1'b1;
              w_m_wdata_nx = w_merged;
              w_tcnt_nx    = '0;
              w_state_nx   = RMW_WR;
            end
            default: w_d_ready_nx = 1'b1;
          endcase
        end else if (w_timeout) begin
          w_m_re_nx  = 1'b0;
          w_m_we_nx  = 1'b0;
          w_err_nx   = 1'b1;
          w_state_nx = IDLE;
          if (r_state == I_RD) begin
            w_i_ready_nx = 1'b1;
            w_i_rdata_nx = '0;
          end else begin
            w_d_ready_nx = 1'b1;
            w_d_rdata_nx = '0;
          end
        end else begin
          w_tcnt_nx = w_tcnt_inc;
        end
      end

      default: begin
        w_state_nx = IDLE;
        w_m_re_nx  = 1'b0;
        w_m_we_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_starve  <= '0;
      r_tcnt    <= '0;
      r_be      <= '0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_we    <= 1'b0;
      r_m_re    <= 1'b0;
      r_i_rdata <= '0;
      r_i_ready <= 1'b0;
      r_d_rdata <= '0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_starve  <= w_starve_nx;
      r_tcnt    <= w_tcnt_nx;
      r_be      <= w_be_nx;
      r_m_addr  <= w_m_addr_nx;
      r_m_wdata <= w_m_wdata_nx;
      r_m_we    <= w_m_we_nx;
      r_m_re    <= w_m_re_nx;
      r_i_rdata <= w_i_rdata_nx;
      r_i_ready <= w_i_ready_nx;
      r_d_rdata <= w_d_rdata_nx;
      r_d_ready <= w_d_ready_nx;
      r_err     <= w_err_nx;
    end
  end

  assign i_rdata = r_i_rdata;
  assign i_ready = r_i_ready;
  assign d_rdata = r_d_rdata;
  assign d_ready = r_d_ready;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_we    = r_m_we;
  assign m_re    = r_m_re;
  assign err     = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the controller is played by hand from one sequence of steps.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic        m_re;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0; m_ready = 1'b0;
    tick(); tick();
    check("rst_outs", {i_rdata[7:0], d_rdata[7:0], m_addr[7:0], m_wdata[1:0],
                       m_we, m_re, i_ready, d_ready, err, 1'b0}, 32'h0);
    check("rst_addr", m_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    // Fetch only
    i_req = 1'b1; i_addr = 32'h104;
    tick();
    check("f_re", m_re, 1); check("f_addr", m_addr, 32'h104); check("f_rdy0", i_ready, 0);
    m_ready = 1'b1; m_rdata = 32'h00100093;
    tick();
    check("f_re_off", m_re, 0); check("f_rdy", i_ready, 1); check("f_data", i_rdata, 32'h00100093);
    i_req = 1'b0; m_ready = 1'b0; m_rdata = '0;
    tick();
    check("f_rdy_pulse", i_ready, 0); check("f_hold", i_rdata, 32'h00100093); check("f_re_idle", m_re, 0);

    // Load and fetch together: data first, fetch after
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2003; i_req = 1'b1; i_addr = 32'h108;
    tick();
    check("lf_daddr", m_addr, 32'h2000); check("lf_re", m_re, 1);
    m_ready = 1'b1; m_rdata = 32'hCAFEBABE;
    tick();
    check("lf_drdy", d_ready, 1); check("lf_ddata", d_rdata, 32'hCAFEBABE);
    check("lf_gap", m_re, 0); check("lf_irdy0", i_ready, 0);
    d_req = 1'b0; m_ready = 1'b0;
    tick();
    check("lf_iaddr", m_addr, 32'h108); check("lf_ire", m_re, 1); check("lf_drdy_off", d_ready, 0);
    m_ready = 1'b1; m_rdata = 32'h13;
    tick();
    check("lf_irdy", i_ready, 1); check("lf_idata", i_rdata, 32'h13);
    i_req = 1'b0; m_ready = 1'b0;
    tick();

    // Byte store via read-modify-write; inputs changed after grant must be ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_be = 4'b0010; d_wdata = 32'h0000AA00;
    tick();
    check("bs_re", m_re, 1); check("bs_we0", m_we, 0); check("bs_addr", m_addr, 32'h2004);
    d_wdata = 32'hFFFFFFFF; d_be = 4'b1111; d_addr = 32'h9990;
    m_ready = 1'b1; m_rdata = 32'h11223344;
    tick();
    check("bs_re_off", m_re, 0); check("bs_we", m_we, 1);
    check("bs_merge", m_wdata, 32'h1122AA44); check("bs_waddr", m_addr, 32'h2004);
    check("bs_rdy_early", d_ready, 0);
    m_ready = 1'b0;
    tick();
    check("bs_we_hold", m_we, 1); check("bs_rdy_wait", d_ready, 0);
    m_ready = 1'b1;
    tick();
    check("bs_we_off", m_we, 0); check("bs_rdy", d_ready, 1); check("bs_rdata_kept", d_rdata, 32'hCAFEBABE);
    d_req = 1'b0; m_ready = 1'b0;
    tick();
    check("bs_rdy_once", d_ready, 0);

    // Starvation: four data grants, then the fetch, then data again
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("st_grant%0d", k), m_addr, 32'h3000);
      m_ready = 1'b1; m_rdata = 32'hA0 + k;
      tick();
      check($sformatf("st_data%0d", k), d_rdata, 32'hA0 + k);
      m_ready = 1'b0;
    end
    tick();
    check("st_fetch", m_addr, 32'h200); check("st_fetch_re", m_re, 1);
    m_ready = 1'b1; m_rdata = 32'h55;
    tick();
    check("st_irdy", i_ready, 1); check("st_idata", i_rdata, 32'h55);
    m_ready = 1'b0;
    tick();
    check("st_reset_cnt", m_addr, 32'h3000);
    m_ready = 1'b1; m_rdata = 32'h77;
    tick();
    check("st_drdy", d_ready, 1);
    d_req = 1'b0; i_req = 1'b0; m_ready = 1'b0;
    tick();

    // Full-word store goes straight to write
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 32'h600B; d_wdata = 32'hDEADBEEF;
    tick();
    check("fw_we", m_we, 1); check("fw_re", m_re, 0);
    check("fw_addr", m_addr, 32'h6008); check("fw_data", m_wdata, 32'hDEADBEEF);
    m_ready = 1'b1;
    tick();
    check("fw_rdy", d_ready, 1); check("fw_rdata_kept", d_rdata, 32'h77);
    d_req = 1'b0; m_ready = 1'b0;
    tick();

    // Empty byte-enable store: no access, immediate ready
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0000; d_addr = 32'h7000;
    tick();
    check("be0_rdy", d_ready, 1); check("be0_strobes", {m_we, m_re}, 0);
    d_req = 1'b0;
    tick();
    check("be0_once", d_ready, 0);

    // Timeout on a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
    tick();
    check("to_re", m_re, 1);
    bad = 1'b0;
    for (int c = 1; c < 255; c++) begin
      tick();
      if (err || !m_re || d_ready) bad = 1'b1;
    end
    check("to_early", bad, 0);
    tick();
    check("to_err", err, 1); check("to_drdy", d_ready, 1);
    check("to_rdata", d_rdata, 32'h0); check("to_re_off", m_re, 0);
    d_req = 1'b0;
    tick();
    check("to_err_pulse", err, 0);

    // Reset during RMW write
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = 32'h5000; d_wdata = 32'hBB;
    tick();
    check("rr_re", m_re, 1);
    m_ready = 1'b1; m_rdata = 32'h0;
    tick();
    check("rr_we", m_we, 1); check("rr_wdata", m_wdata, 32'hBB);
    m_ready = 1'b0; rst_n = 1'b0; d_req = 1'b0;
    tick();
    check("rr_strobes", {m_we, m_re, d_ready, err}, 0);
    check("rr_addr", m_addr, 32'h0); check("rr_wd0", m_wdata, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rr_no_rdy", {d_ready, m_we}, 0);
    i_req = 1'b1; i_addr = 32'h300;
    tick();
    check("rr_f_addr", m_addr, 32'h300); check("rr_f_re", m_re, 1);
    m_ready = 1'b1; m_rdata = 32'h99;
    tick();
    check("rr_f_rdy", i_ready, 1); check("rr_f_data", i_rdata, 32'h99);
    i_req = 1'b0; m_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
